sort_mem_responder: RTL and testbench
=====================================

# sort_mem_responder

Memory-side responder for the bubble-sort engine. It owns the DEPTH-word data array and accepts a host stream to fill the array. It then serves the sort controller's single-cycle rd/wr accesses until the controller reports completion, and finally streams the sorted array back out through a valid/ready port. It sits between the host interface and the sort datapath, replacing a bare register array.

## Interface

Parameters:
- DW, 8, data word width
- DEPTH, 8, number of words; power of two, ≥2
- AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  begin a load; honoured only in IDLE
- ld_valid  in  1  host load word valid
- ld_data  in  DW  host load word
- ld_ready  out  1  responder accepts a load word
- loaded  out  1  one-cycle pulse: array full, sort access enabled
- rd  in  1  sort read request
- wr  in  1  sort write request
- addr  in  AW  sort access address
- wdata  in  DW  sort write data
- rdata  out  DW  sort read data
- sort_done  in  1  sort controller finished (level or pulse)
- ul_valid  out  1  unload word valid
- ul_data  out  DW  unload word
- ul_ready  in  1  host accepts unload word
- unload_done  out  1  one-cycle pulse: last word unloaded
- sort_err  out  1  sticky order-violation flag (see Configuration)

## Operation

- States: IDLE, LOAD, SERVE, UNLOAD. Word counter cnt is AW+1 bits wide.
- IDLE: if load_start=1, go to LOAD with cnt←0. Otherwise stay.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid=1 writes mem[cnt]←ld_data and increments cnt.
  - When the beat with cnt=DEPTH-1 is accepted, go to SERVE.
- SERVE:
  - rdata = mem[addr] combinationally when rd=1; otherwise rdata=0.
  - When wr=1, mem[addr]←wdata on the clock edge.
  - When rd=1 and wr=1 in the same cycle, rdata returns the pre-write value.
  - When sort_done=1, go to UNLOAD with cnt←0. An access issued in that same cycle is still performed.
- UNLOAD:
  - ul_valid=1 and ul_data=mem[cnt].
  - A beat transfers when ul_valid and ul_ready are both high; cnt then increments.
  - After the beat with cnt=DEPTH-1 transfers, go to IDLE.
- rd/wr outside SERVE are ignored: the array is unchanged and rdata=0.
- load_start outside IDLE is ignored.
- sort_done outside SERVE is ignored.
- Memory contents persist from UNLOAD into IDLE. A new LOAD overwrites every entry.

## Timing

- Reset values:
  - State: IDLE; cnt=0.
  - Outputs: ld_ready=0, loaded=0, rdata=0, ul_valid=0, ul_data=0, unload_done=0, sort_err=0.
  - All array words are cleared to 0.
- Reset asserted mid-operation in any state aborts the operation immediately. No partial pulses are emitted.
- ld_ready, ul_valid, ul_data and rdata are decoded combinationally from state, cnt and addr.
- loaded is registered and high in the first SERVE cycle. That is the cycle after the last load beat.
- sort_done sampled high at edge N makes ul_valid=1 in cycle N+1.
- ul_data is held stable while ul_valid=1 and ul_ready=0.
- unload_done is registered and high in the first IDLE cycle after the last unload beat.
- Full load latency is DEPTH cycles with ld_valid held high. Full unload latency is DEPTH cycles with ul_ready held high.

## Configuration

- SORT_MEM_CHECK_EN defined: during UNLOAD, each transferred word is compared unsigned with the previously transferred word.
  - If the current word is less than the previous word, sort_err←1 on that edge.
  - The first beat is never compared.
  - sort_err stays high until reset or an accepted load_start.
- SORT_MEM_CHECK_EN undefined: no comparator and no previous-word register; sort_err is tied to 0.

## Structure

- Package sort_mem_pkg holds the state enum (IDLE/LOAD/SERVE/UNLOAD) and the default DW/DEPTH constants.
- One sub-module, sort_mem_array:
  - DEPTH×DW storage with asynchronous clear and synchronous write.
  - Two asynchronous read ports: one for the sort port, one for the unload port.
- The write-port mux (load vs. sort) and the FSM live in the top.

## Test plan

- Load 5,3,7,1,8,2,6,4 with ld_valid held high → ld_ready high for 8 cycles, then loaded pulses once; rd with addr=2 returns 7 in the same cycle.
- In SERVE, wr addr=3 wdata=0x55 → next cycle rd addr=3 returns 0x55. Same-cycle rd+wr to addr=0 with 0xAA → rdata=5 that cycle, then 0xAA afterwards.
- Pulse sort_done, then drive ul_ready alternating 1,0 → 8 beats in address order, ul_data stable during stalls, unload_done pulses once, state returns to IDLE.
- rd/wr with addr=1 and wdata=0xFF issued in IDLE and in LOAD → rdata=0 throughout; a later unload shows addr 1 unchanged.
- Assert rst after 3 load beats → all outputs 0 and the array cleared; a new load_start fills from address 0.
- With SORT_MEM_CHECK_EN, unload 1,2,3,9,4,5,6,7 → sort_err rises on the 5th beat and holds until the next load_start.

Source files
------------

// File: rtl/sort_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_mem_pkg
// Purpose  : Shared types and default sizing for the sort memory responder.
//            Holds the responder state enum and the default DW/DEPTH values.
// Revision : 1.0 - initial release
// ============================================================================
package sort_mem_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SERVE  = 2'd2,
        UNLOAD = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sort_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : sort_mem_array
// Purpose  : DEPTH x DW register array with asynchronous clear, one
//            synchronous write port and two asynchronous read ports.
// Ports    : clk, rst          - clock, async active-high clear
//            we/waddr/wdata    - write port (rising edge)
//            raddr_a/rdata_a   - combinational read port A (sort side)
//            raddr_b/rdata_b   - combinational read port B (unload side)
// Revision : 1.0 - initial release
// ============================================================================
module sort_mem_array #(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [DW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [DW-1:0] rdata_b
);

    logic [DW-1:0] mem [DEPTH];

    // One register per word so each entry gets its own clear and enable.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (we && (waddr == AW'(i))) begin
                mem[i] <= wdata;
            end
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule
`default_nettype wire

// File: rtl/sort_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sort_mem_responder
// Purpose  : Memory-side responder for the bubble-sort engine. Fills the
//            array from a host load stream, serves single-cycle sort rd/wr
//            accesses until sort_done, then streams the array back out.
// Ports    : clk, rst (async, active-high)
//            load_start, ld_valid, ld_data, ld_ready, loaded  - load side
//            rd, wr, addr, wdata, rdata, sort_done             - sort side
//            ul_valid, ul_data, ul_ready, unload_done          - unload side
//            sort_err                                          - order flag
// Config   : SORT_MEM_CHECK_EN - when defined, unloaded words are checked
//            for ascending order and sort_err latches on a violation;
//            otherwise sort_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module sort_mem_responder
    import sort_mem_pkg::*;
#(
    parameter  int DW    = DEFAULT_DW,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          loaded,
    input  logic          rd,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    input  logic          sort_done,
    output logic          ul_valid,
    output logic [DW-1:0] ul_data,
    input  logic          ul_ready,
    output logic          unload_done,
    output logic          sort_err
);

    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    state_t        state;
    logic [AW:0]   cnt;
    logic [AW-1:0] idx;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] sort_word;
    logic [DW-1:0] unload_word;

    logic          load_go;
    logic          ul_beat;

    assign idx     = cnt[AW-1:0];
    assign load_go = (state == IDLE) && load_start;
    assign ul_beat = (state == UNLOAD) && ul_ready;

    // Write-port mux: host stream owns the array in LOAD, sort port in SERVE.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = ld_data;
        case (state)
            LOAD: begin
                mem_we = ld_valid;
            end
            SERVE: begin
                mem_we    = wr;
                mem_waddr = addr;
                mem_wdata = wdata;
            end
            default: begin
            end
        endcase
    end

    sort_mem_array #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (addr),
        .rdata_a (sort_word),
        .raddr_b (idx),
        .rdata_b (unload_word)
    );

    // Read data is the pre-edge array content, so a same-cycle rd+wr
    // naturally returns the old value.
    assign rdata    = ((state == SERVE) && rd) ? sort_word : '0;
    assign ld_ready = (state == LOAD);
    assign ul_valid = (state == UNLOAD);
    assign ul_data  = (state == UNLOAD) ? unload_word : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            loaded      <= 1'b0;
            unload_done <= 1'b0;
        end else begin
            loaded      <= 1'b0;
            unload_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state  <= SERVE;
                            loaded <= 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (sort_done) begin
                        state <= UNLOAD;
                        cnt   <= '0;
                    end
                end
                UNLOAD: begin
                    if (ul_ready) begin
                        if (cnt == LAST) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            unload_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef SORT_MEM_CHECK_EN
    logic [DW-1:0] prev_word;
    logic          err_q;

    // The first beat (cnt == 0) has no predecessor and is never compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_word <= '0;
            err_q     <= 1'b0;
        end else begin
            if (load_go) begin
                err_q <= 1'b0;
            end else if (ul_beat && (cnt != '0) && (ul_data < prev_word)) begin
                err_q <= 1'b1;
            end
            if (ul_beat) begin
                prev_word <= ul_data;
            end
        end
    end

    assign sort_err = err_q;
`else
    assign sort_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_mem_responder
// Purpose  : Directed self-checking bench for sort_mem_responder (DW=8,
//            DEPTH=8). Covers reset, load, serve access ordering, stalled
//            unload, ignored accesses outside SERVE, mid-load reset and the
//            optional SORT_MEM_CHECK_EN order checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort_mem_responder;

`ifdef SORT_MEM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start, ld_valid, ld_ready, loaded;
    logic [7:0] ld_data;
    logic       rd, wr;
    logic [2:0] addr;
    logic [7:0] wdata, rdata;
    logic       sort_done, ul_valid, ul_ready, unload_done, sort_err;
    logic [7:0] ul_data;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] load1 [8] = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
    logic [7:0] exp1  [8] = '{8'hAA, 8'd3, 8'd7, 8'h55, 8'd8, 8'd2, 8'd6, 8'd4};
    logic [7:0] load2 [8] = '{8'd1, 8'd2, 8'd3, 8'd9, 8'd4, 8'd5, 8'd6, 8'd7};

    sort_mem_responder #(.DW(8), .DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .loaded      (loaded),
        .rd          (rd),
        .wr          (wr),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .sort_done   (sort_done),
        .ul_valid    (ul_valid),
        .ul_data     (ul_data),
        .ul_ready    (ul_ready),
        .unload_done (unload_done),
        .sort_err    (sort_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs change and checks happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".ld_ready"},    32'(ld_ready),    32'd0);
        check({tag, ".loaded"},      32'(loaded),      32'd0);
        check({tag, ".rdata"},       32'(rdata),       32'd0);
        check({tag, ".ul_valid"},    32'(ul_valid),    32'd0);
        check({tag, ".ul_data"},     32'(ul_data),     32'd0);
        check({tag, ".unload_done"}, 32'(unload_done), 32'd0);
    endtask

    initial begin
        logic err_model;
        rst = 1'b1; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sort_done = 1'b0; ul_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        #1;
        check_idle_outputs("reset");
        check("reset.sort_err", 32'(sort_err), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- accesses ignored in IDLE ----------------
        rd = 1'b1; wr = 1'b1; addr = 3'd1; wdata = 8'hFF; #1;
        check("idle.rdata", 32'(rdata), 32'd0);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;

        // ---------------- LOAD, with stray rd/wr to addr 1 ----------------
        ld_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ld_data = load1[i]; #1;
            check($sformatf("load%0d.ld_ready", i), 32'(ld_ready), 32'd1);
            check($sformatf("load%0d.rdata", i),    32'(rdata),    32'd0);
            check($sformatf("load%0d.loaded", i),   32'(loaded),   32'd0);
            tick();
        end
        ld_valid = 1'b0; wr = 1'b0; rd = 1'b1; addr = 3'd2; #1;
        check("serve0.loaded",   32'(loaded),   32'd1);
        check("serve0.ld_ready", 32'(ld_ready), 32'd0);
        check("serve0.rd2",      32'(rdata),    32'd7);
        rd = 1'b0; #1;
        check("serve0.rdata_norf", 32'(rdata), 32'd0);

        // write addr3 = 0x55
        wr = 1'b1; addr = 3'd3; wdata = 8'h55;
        tick();
        check("serve1.loaded", 32'(loaded), 32'd0);
        wr = 1'b0; rd = 1'b1; #1;
        check("serve.rd3", 32'(rdata), 32'h55);
        // same-cycle rd+wr to addr 0
        wr = 1'b1; addr = 3'd0; wdata = 8'hAA; #1;
        check("serve.rdwr0_old", 32'(rdata), 32'd5);
        tick();
        wr = 1'b0; #1;
        check("serve.rd0_new", 32'(rdata), 32'hAA);
        rd = 1'b0;

        // ---------------- UNLOAD with alternating ul_ready ----------------
        sort_done = 1'b1;
        tick();
        sort_done = 1'b0;
        err_model = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ul_ready = 1'b0; #1;
            check($sformatf("ul%0d.valid", k), 32'(ul_valid), 32'd1);
            check($sformatf("ul%0d.data", k),  32'(ul_data),  32'(exp1[k]));
            tick();
            ul_ready = 1'b1; #1;
            check($sformatf("ul%0d.stall_data", k), 32'(ul_data), 32'(exp1[k]));
            check($sformatf("ul%0d.unload_done", k), 32'(unload_done), 32'd0);
            check($sformatf("ul%0d.sort_err", k), 32'(sort_err), 32'(CHK & err_model));
            if (k > 0 && exp1[k] < exp1[k-1]) err_model = 1'b1;
            tick();
        end
        ul_ready = 1'b0; #1;
        check("ul.end_valid",       32'(ul_valid),    32'd0);
        check("ul.end_unload_done", 32'(unload_done), 32'd1);
        check("ul.end_sort_err",    32'(sort_err),    32'(CHK & err_model));
        tick();
        check("idle.unload_done_clr", 32'(unload_done), 32'd0);
        check("idle.ul_valid",        32'(ul_valid),    32'd0);

        // ---------------- reset after 3 load beats ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0; #1;
        check("reload.sort_err_clr", 32'(sort_err), 32'd0);
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = 8'hEE;
            tick();
        end
        rst = 1'b1; #1;
        check_idle_outputs("midrst");
        check("midrst.sort_err", 32'(sort_err), 32'd0);
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        tick();
        check_idle_outputs("postrst");

        // ---------------- fresh load fills from addr 0 ----------------
        load_start = 1'b1;
        tick();
        load_start = 1'b0; ld_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ld_data = load2[i];
            tick();
        end
        ld_valid = 1'b0; #1;
        check("load2.loaded", 32'(loaded), 32'd1);
        sort_done = 1'b1;
        tick();
        sort_done = 1'b0; ul_ready = 1'b1;
        err_model = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("ul2_%0d.data", k),     32'(ul_data),  32'(load2[k]));
            check($sformatf("ul2_%0d.sort_err", k), 32'(sort_err), 32'(CHK & (k >= 5)));
            tick();
        end
        ul_ready = 1'b0; #1;
        check("ul2.unload_done", 32'(unload_done), 32'd1);
        check("ul2.sort_err",    32'(sort_err),    32'(CHK));
        tick();
        check("ul2.err_hold", 32'(sort_err), 32'(CHK));
        load_start = 1'b1;
        tick();
        load_start = 1'b0; #1;
        check("reload2.sort_err_clr", 32'(sort_err), 32'd0);
        check("reload2.ld_ready",     32'(ld_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
